// File: rtl/timer_periph.sv
// Purpose : CPU-mapped 16-bit timer with prescaler, up/continuous(/up-down) modes and one IRQ.
// Latency : register reads are combinational; writes and count updates land on the next MCLK edge.
// Backpress: none -- every bus access completes in one cycle, no stall path exists.
//
// Register window (word-aligned at BASE_ADDR):
//   +0 CTL  : [7:6] ID divide /1,/2,/4,/8 ; [5:4] MC 00 stop,01 up,10 continuous,11 up/down
//             [2] CLR (self-clearing, reads 0) ; [1] IE ; [0] IFG ; other bits read 0
//   +2 R    : 16-bit counter
//   +4 CCR0 : 16-bit compare/period register
//
// Ports:
//   MCLK        in   system clock, all state on rising edge
//   reset       in   synchronous active-low reset
//   MAB         in   [15:0] CPU address
//   MDBout      in   [15:0] CPU write data
//   MW          in   write strobe (1 = write)
//   BW          in   access width (1 = byte, 0 = word)
//   INTACK      in   CPU interrupt acknowledge
//   MDBin       out  [15:0] read data, zero when not selected (OR-combinable bus)
//   INT         out  interrupt request = IFG & IE
//   IntAddrLSBs out  [5:0] constant vector LSBs
//
// Build option: define TIMER_UPDOWN_EN to enable up/down counting for MC=11.
// Without it MC=11 is a stop mode that still reads back as written, and no
// direction flop is built.

module timer_periph #(
    parameter logic [15:0] BASE_ADDR   = 16'h0340,
    parameter logic [5:0]  VECTOR_LSBS = 6'h35
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic [15:0] MAB,
    input  logic [15:0] MDBout,
    input  logic        MW,
    input  logic        BW,
    input  logic        INTACK,
    output logic [15:0] MDBin,
    output logic        INT,
    output logic [5:0]  IntAddrLSBs
);

    localparam logic [1:0]  MC_STOP = 2'b00;
    localparam logic [1:0]  MC_UP   = 2'b01;
    localparam logic [1:0]  MC_CONT = 2'b10;
    localparam logic [1:0]  MC_UPDN = 2'b11;

    localparam logic [15:0] ADDR_CTL  = BASE_ADDR;
    localparam logic [15:0] ADDR_R    = BASE_ADDR + 16'd2;
    localparam logic [15:0] ADDR_CCR0 = BASE_ADDR + 16'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  r_id;
    logic [1:0]  r_mc;
    logic        r_ie;
    logic        r_ifg;
    logic [15:0] r_cnt;
    logic [15:0] r_ccr0;
    logic [2:0]  r_presc;
`ifdef TIMER_UPDOWN_EN
    logic        r_dir;          // 0 = counting up, 1 = counting down
`endif

    // ------------------------------------------------------------------
    // Address decode and write qualification
    // ------------------------------------------------------------------
    logic        w_sel_ctl;
    logic        w_sel_r;
    logic        w_sel_ccr0;
    logic        w_sel_any;
    logic        w_wr_ctl;
    logic        w_wr_r;
    logic        w_wr_ccr0;
    logic        w_wr_lo;        // access touches the low byte
    logic        w_ctl_lo_wr;    // CTL write that carries the control bits
    logic        w_clr;
    logic        w_mode_chg;

    assign w_sel_ctl  = (MAB[15:1] == ADDR_CTL[15:1]);
    assign w_sel_r    = (MAB[15:1] == ADDR_R[15:1]);
    assign w_sel_ccr0 = (MAB[15:1] == ADDR_CCR0[15:1]);
    assign w_sel_any  = w_sel_ctl | w_sel_r | w_sel_ccr0;

    assign w_wr_ctl   = MW & w_sel_ctl;
    assign w_wr_r     = MW & w_sel_r;
    assign w_wr_ccr0  = MW & w_sel_ccr0;

    assign w_wr_lo    = ~BW | ~MAB[0];

    // CTL's upper byte holds no state, so only low-byte/word writes matter.
    // Both carry the control bits on MDBout[7:0].
    assign w_ctl_lo_wr = w_wr_ctl & w_wr_lo;
    assign w_clr       = w_ctl_lo_wr & MDBout[2];
    assign w_mode_chg  = w_ctl_lo_wr & ((MDBout[7:6] != r_id) | (MDBout[5:4] != r_mc));

    // Byte-lane merge: a byte write to either half takes its data from MDBout[7:0].
    function automatic logic [15:0] f_merge(input logic [15:0] old_v,
                                            input logic [15:0] wdat,
                                            input logic        bw,
                                            input logic        odd);
        logic [15:0] res;
        if (!bw) begin
            res = wdat;
        end else if (odd) begin
            res = {wdat[7:0], old_v[7:0]};
        end else begin
            res = {old_v[15:8], wdat[7:0]};
        end
        return res;
    endfunction

    logic [15:0] w_r_wdat;
    logic [15:0] w_ccr0_wdat;

    assign w_r_wdat    = f_merge(r_cnt,  MDBout, BW, MAB[0]);
    assign w_ccr0_wdat = f_merge(r_ccr0, MDBout, BW, MAB[0]);

    // ------------------------------------------------------------------
    // Read path (combinational, zero when not selected)
    // ------------------------------------------------------------------
    logic [15:0] w_ctl_rd;
    logic [15:0] w_reg_rd;

    assign w_ctl_rd = {8'h00, r_id, r_mc, 2'b00, r_ie, r_ifg};

    always_comb begin
        w_reg_rd = 16'h0000;
        if (w_sel_ctl) begin
            w_reg_rd = w_ctl_rd;
        end else if (w_sel_r) begin
            w_reg_rd = r_cnt;
        end else if (w_sel_ccr0) begin
            w_reg_rd = r_ccr0;
        end
    end

    always_comb begin
        MDBin = 16'h0000;
        if (w_sel_any) begin
            if (!BW) begin
                MDBin = w_reg_rd;
            end else if (MAB[0]) begin
                MDBin = {8'h00, w_reg_rd[15:8]};
            end else begin
                MDBin = {8'h00, w_reg_rd[7:0]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler / tick generation
    // ------------------------------------------------------------------
    logic       w_running;
    logic [2:0] w_mask;
    logic       w_tick;

    always_comb begin
        w_running = 1'b0;
        case (r_mc)
            MC_UP:   w_running = 1'b1;
            MC_CONT: w_running = 1'b1;
`ifdef TIMER_UPDOWN_EN
            MC_UPDN: w_running = 1'b1;
`endif
            default: w_running = 1'b0;
        endcase
    end

    always_comb begin
        w_mask = 3'd0;
        case (r_id)
            2'd0:    w_mask = 3'd0;
            2'd1:    w_mask = 3'd1;
            2'd2:    w_mask = 3'd3;
            default: w_mask = 3'd7;
        endcase
    end

    // Tick on the last cycle of each 2^ID window; the prescaler restarts at 0
    // after it, so the first tick after a restart lands 2^ID cycles later.
    assign w_tick = w_running & ((r_presc & w_mask) == w_mask);

    // ------------------------------------------------------------------
    // Counter next value on a tick
    // ------------------------------------------------------------------
    logic [15:0] w_cnt_tick;
    logic        w_ifg_evt;
`ifdef TIMER_UPDOWN_EN
    logic        w_dir_nxt;
`endif

    always_comb begin
        w_cnt_tick = r_cnt;
        w_ifg_evt  = 1'b0;
`ifdef TIMER_UPDOWN_EN
        w_dir_nxt  = r_dir;
`endif
        case (r_mc)
            MC_UP: begin
                if (r_ccr0 == 16'h0000) begin
                    w_cnt_tick = 16'h0000;
                end else if (r_cnt < r_ccr0) begin
                    w_cnt_tick = r_cnt + 16'd1;
                end else begin
                    w_cnt_tick = 16'h0000;
                    w_ifg_evt  = 1'b1;
                end
            end
            MC_CONT: begin
                w_cnt_tick = r_cnt + 16'd1;
                w_ifg_evt  = (r_cnt == 16'hFFFF);
            end
`ifdef TIMER_UPDOWN_EN
            MC_UPDN: begin
                if (r_ccr0 == 16'h0000) begin
                    w_cnt_tick = 16'h0000;
                    w_dir_nxt  = 1'b0;
                end else if (!r_dir && (r_cnt < r_ccr0)) begin
                    w_cnt_tick = r_cnt + 16'd1;
                end else if (r_cnt <= 16'd1) begin
                    // Bottom of the down slope (also covers CCR0=1 where the
                    // turn-around step is itself the 1 -> 0 step).
                    w_cnt_tick = 16'h0000;
                    w_ifg_evt  = (r_cnt == 16'd1);
                    w_dir_nxt  = 1'b0;
                end else begin
                    w_cnt_tick = r_cnt - 16'd1;
                    w_dir_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                w_cnt_tick = r_cnt;
            end
        endcase
    end

    // A CPU write to R or a CLR in the same cycle discards the tick entirely,
    // including any flag it would have raised.
    logic w_tick_apply;
    logic w_ifg_set;

    assign w_tick_apply = w_tick & ~w_wr_r & ~w_clr;
    assign w_ifg_set    = w_tick_apply & w_ifg_evt;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (!reset) begin
            r_id   <= 2'd0;
            r_mc   <= MC_STOP;
            r_ie   <= 1'b0;
            r_ifg  <= 1'b0;
        end else begin
            if (w_ctl_lo_wr) begin
                r_id <= MDBout[7:6];
                r_mc <= MDBout[5:4];
                r_ie <= MDBout[1];
            end
            // Hardware set beats both clear sources.
            if (w_ifg_set) begin
                r_ifg <= 1'b1;
            end else if (w_ctl_lo_wr) begin
                r_ifg <= MDBout[0];
            end else if (INTACK && INT) begin
                r_ifg <= 1'b0;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (!reset) begin
            r_ccr0 <= 16'h0000;
        end else if (w_wr_ccr0) begin
            r_ccr0 <= w_ccr0_wdat;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!reset) begin
            r_cnt <= 16'h0000;
        end else if (w_wr_r) begin
            r_cnt <= w_r_wdat;
        end else if (w_clr) begin
            r_cnt <= 16'h0000;
        end else if (w_tick_apply) begin
            r_cnt <= w_cnt_tick;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!reset) begin
            r_presc <= 3'd0;
        end else if (w_clr || w_mode_chg || !w_running) begin
            r_presc <= 3'd0;
        end else if (w_tick) begin
            r_presc <= 3'd0;
        end else begin
            r_presc <= r_presc + 3'd1;
        end
    end

`ifdef TIMER_UPDOWN_EN
    always_ff @(posedge MCLK) begin
        if (!reset) begin
            r_dir <= 1'b0;
        end else if (w_clr) begin
            r_dir <= 1'b0;
        end else if (w_tick_apply) begin
            r_dir <= w_dir_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign INT         = r_ifg & r_ie;
    assign IntAddrLSBs = VECTOR_LSBS;

endmodule

// File: tb/tb_timer_periph.sv
// Purpose : directed self-checking bench for timer_periph.
// Latency : inputs change 1 time unit after a rising edge; outputs sampled before the next edge.
// Backpress: not applicable.

module tb_timer_periph;

    localparam logic [15:0] BASE = 16'h0340;
    localparam logic [15:0] A_CTL  = BASE;
    localparam logic [15:0] A_R    = BASE + 16'd2;
    localparam logic [15:0] A_CCR0 = BASE + 16'd4;

    logic        MCLK;
    logic        reset;
    logic [15:0] MAB;
    logic [15:0] MDBout;
    logic        MW;
    logic        BW;
    logic        INTACK;
    logic [15:0] MDBin;
    logic        INT;
    logic [5:0]  IntAddrLSBs;

    int total;
    int bad;

    timer_periph #(
        .BASE_ADDR   (16'h0340),
        .VECTOR_LSBS (6'h35)
    ) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .MAB         (MAB),
        .MDBout      (MDBout),
        .MW          (MW),
        .BW          (BW),
        .INTACK      (INTACK),
        .MDBin       (MDBin),
        .INT         (INT),
        .IntAddrLSBs (IntAddrLSBs)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic bw);
        MAB    = a;
        MDBout = d;
        BW     = bw;
        MW     = 1'b1;
        step();
        MW     = 1'b0;
        BW     = 1'b0;
        MAB    = 16'h0000;
        MDBout = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, input logic bw, output logic [15:0] d);
        MAB = a;
        BW  = bw;
        MW  = 1'b0;
        #1;
        d   = MDBin;
        MAB = 16'h0000;
        BW  = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL reset_int got=%b exp=0", INT); end
        total++; if (MDBin !== 16'h0000) begin bad++; $display("FAIL reset_mdbin_unsel got=%h exp=0000", MDBin); end
        total++; if (IntAddrLSBs !== 6'h35) begin bad++; $display("FAIL reset_vec got=%h exp=35", IntAddrLSBs); end
        rd(A_CTL, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_ctl got=%h exp=0000", d); end
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_r got=%h exp=0000", d); end
        rd(A_CCR0, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_ccr0 got=%h exp=0000", d); end
    endtask

    task automatic test_regs();
        logic [15:0] d;
        wr(A_CCR0, 16'hA5C3, 1'b0);
        rd(A_CCR0, 1'b0, d);
        total++; if (d !== 16'hA5C3) begin bad++; $display("FAIL ccr0_word got=%h exp=a5c3", d); end
        rd(A_CCR0, 1'b1, d);
        total++; if (d !== 16'h00C3) begin bad++; $display("FAIL ccr0_byte_lo got=%h exp=00c3", d); end
        rd(A_CCR0 + 16'd1, 1'b1, d);
        total++; if (d !== 16'h00A5) begin bad++; $display("FAIL ccr0_byte_hi got=%h exp=00a5", d); end
        wr(A_CCR0 + 16'd1, 16'h447E, 1'b1);
        rd(A_CCR0, 1'b0, d);
        total++; if (d !== 16'h7EC3) begin bad++; $display("FAIL ccr0_bytewr_hi got=%h exp=7ec3", d); end
        rd(BASE + 16'd6, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL unsel_above got=%h exp=0000", d); end
        rd(BASE - 16'd2, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL unsel_below got=%h exp=0000", d); end
        wr(A_R, 16'h1234, 1'b0);
        wr(A_R, 16'h99AB, 1'b1);
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h12AB) begin bad++; $display("FAIL r_bytewr_lo got=%h exp=12ab", d); end
        // All-ones CTL: CLR and the unused bits read 0, IE & IFG raise INT.
        wr(A_CTL, 16'hFFFF, 1'b0);
        rd(A_CTL, 1'b0, d);
        total++; if (d !== 16'h00F3) begin bad++; $display("FAIL ctl_readback got=%h exp=00f3", d); end
        total++; if (INT !== 1'b1) begin bad++; $display("FAIL ctl_int_set got=%b exp=1", INT); end
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL ctl_clr_r got=%h exp=0000", d); end
        wr(A_CTL, 16'h0000, 1'b0);
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL ctl_int_clr got=%b exp=0", INT); end
    endtask

    task automatic test_up_mode();
        logic [15:0] d;
        logic [15:0] exp_r [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
        logic        exp_i [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        wr(A_CTL, 16'h0004, 1'b0);
        wr(A_CCR0, 16'h0004, 1'b0);
        wr(A_CTL, 16'h0012, 1'b0);
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL up_start got=%h exp=0000", d); end
        for (int k = 0; k < 5; k++) begin
            step();
            rd(A_R, 1'b0, d);
            total++; if (d !== exp_r[k]) begin bad++; $display("FAIL up_r[%0d] got=%h exp=%h", k, d, exp_r[k]); end
            total++; if (INT !== exp_i[k]) begin bad++; $display("FAIL up_int[%0d] got=%b exp=%b", k, INT, exp_i[k]); end
        end
        rd(A_CTL, 1'b0, d);
        total++; if (d !== 16'h0013) begin bad++; $display("FAIL up_ctl_ifg got=%h exp=0013", d); end
        INTACK = 1'b1;
        step();
        INTACK = 1'b0;
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL up_intack got=%b exp=0", INT); end
        // CCR0 = 0: counter parks at 0 and never flags.
        wr(A_CTL, 16'h0004, 1'b0);
        wr(A_CCR0, 16'h0000, 1'b0);
        wr(A_CTL, 16'h0012, 1'b0);
        repeat (5) step();
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL up_ccr0_zero_r got=%h exp=0000", d); end
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL up_ccr0_zero_int got=%b exp=0", INT); end
        wr(A_CTL, 16'h0000, 1'b0);
    endtask

    task automatic test_continuous();
        logic [15:0] d;
        wr(A_R, 16'hFFFE, 1'b0);
        wr(A_CTL, 16'h00E2, 1'b0);
        repeat (7) step();
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'hFFFE) begin bad++; $display("FAIL cont_r_7 got=%h exp=fffe", d); end
        step();
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'hFFFF) begin bad++; $display("FAIL cont_r_8 got=%h exp=ffff", d); end
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL cont_int_8 got=%b exp=0", INT); end
        repeat (7) step();
        rd(A_R + 16'd1, 1'b1, d);
        total++; if (d !== 16'h00FF) begin bad++; $display("FAIL cont_byte_hi got=%h exp=00ff", d); end
        step();
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL cont_wrap got=%h exp=0000", d); end
        total++; if (INT !== 1'b1) begin bad++; $display("FAIL cont_wrap_int got=%b exp=1", INT); end
        wr(A_CTL, 16'h0000, 1'b0);
    endtask

    task automatic test_updown();
        logic [15:0] d;
`ifdef TIMER_UPDOWN_EN
        logic [15:0] exp_r [7] = '{16'd1, 16'd2, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1};
        logic        exp_i [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        logic [15:0] exp_r [7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        logic        exp_i [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        wr(A_CTL, 16'h0004, 1'b0);
        wr(A_CCR0, 16'h0003, 1'b0);
        wr(A_CTL, 16'h0032, 1'b0);
        rd(A_CTL, 1'b0, d);
        total++; if (d !== 16'h0032) begin bad++; $display("FAIL updn_ctl got=%h exp=0032", d); end
        for (int k = 0; k < 7; k++) begin
            step();
            rd(A_R, 1'b0, d);
            total++; if (d !== exp_r[k]) begin bad++; $display("FAIL updn_r[%0d] got=%h exp=%h", k, d, exp_r[k]); end
            total++; if (INT !== exp_i[k]) begin bad++; $display("FAIL updn_int[%0d] got=%b exp=%b", k, INT, exp_i[k]); end
        end
        wr(A_CTL, 16'h0000, 1'b0);
    endtask

    task automatic test_collision();
        logic [15:0] d;
        wr(A_CTL, 16'h0004, 1'b0);
        wr(A_CTL, 16'h0020, 1'b0);
        repeat (3) step();
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0003) begin bad++; $display("FAIL coll_pre got=%h exp=0003", d); end
        wr(A_R, 16'h0010, 1'b0);
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0010) begin bad++; $display("FAIL coll_r_write got=%h exp=0010", d); end
        step();
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0011) begin bad++; $display("FAIL coll_resume got=%h exp=0011", d); end
        wr(A_R, 16'hFFFF, 1'b0);
        wr(A_CTL, 16'h0022, 1'b0);
        rd(A_CTL, 1'b0, d);
        total++; if (d !== 16'h0023) begin bad++; $display("FAIL coll_ifg_wins got=%h exp=0023", d); end
        total++; if (INT !== 1'b1) begin bad++; $display("FAIL coll_int got=%b exp=1", INT); end
        wr(A_CTL, 16'h0022, 1'b0);
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL coll_plain_clear got=%b exp=0", INT); end
        wr(A_CTL, 16'h0000, 1'b0);
    endtask

    task automatic test_reset_midcount();
        logic [15:0] d;
        wr(A_CTL, 16'h0004, 1'b0);
        wr(A_CCR0, 16'h0055, 1'b0);
        wr(A_R, 16'h1234, 1'b0);
        wr(A_CTL, 16'h00E3, 1'b0);
        total++; if (INT !== 1'b1) begin bad++; $display("FAIL mid_int_pre got=%b exp=1", INT); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL mid_int got=%b exp=0", INT); end
        rd(A_CTL, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL mid_ctl got=%h exp=0000", d); end
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL mid_r got=%h exp=0000", d); end
        rd(A_CCR0, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL mid_ccr0 got=%h exp=0000", d); end
        repeat (20) step();
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL mid_stopped got=%h exp=0000", d); end
        wr(A_CTL, 16'h0020, 1'b0);
        step();
        step();
        rd(A_R, 1'b0, d);
        total++; if (d !== 16'h0002) begin bad++; $display("FAIL mid_restart got=%h exp=0002", d); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        MAB    = 16'h0000;
        MDBout = 16'h0000;
        MW     = 1'b0;
        BW     = 1'b0;
        INTACK = 1'b0;
        test_reset();
        test_regs();
        test_up_mode();
        test_continuous();
        test_updown();
        test_collision();
        test_reset_midcount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
